alu_issue_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU between two requesters, lane 0 and lane 1, such as two pipeline stages or a pipeline stage and a debug/MMIO port.
- Arbitrates round-robin and registers the winning operation.
- Holds the ALU inputs stable for an op-dependent number of cycles so multiply/divide can settle in multicycle timing.
- Captures Out/R/signFlag and returns them with a lane tag over a valid/ready response channel.

---
 rtl/alu_issue_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares one combinational WIDTH-bit ALU between two requesters (lane 0 and
// lane 1). A round-robin arbiter picks one request while idle. The winning
// opcode and operands are registered onto the ALU inputs and held there for an
// opcode-dependent number of cycles, so a slow multiply or divide path can
// settle under multicycle timing. The ALU results are then captured and
// returned with the issuing lane's tag over a valid/ready response channel.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   reqN_valid/op/a/b (N=0,1)  request from lane N, held until reqN_ready
//   reqN_ready                 lane N is accepted on this edge (combinational)
//   alu_a/alu_b/alu_op         registered operands and opcode driving the ALU
//   alu_out/alu_r/alu_sign     ALU result, remainder/product-high, sign flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     lane that issued the returned result
//   rsp_out/rsp_r/rsp_sign     captured ALU results
//   rsp_err                    divide-by-zero indication
//   busy                       an operation is executing or awaiting pickup
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_sign,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_sign,
    output logic             rsp_err,
    output logic             busy
);

    // The counter only has to reach the longest latency minus one.
    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [2:0]       OP_MUL  = 3'b010;
    localparam logic [2:0]       OP_DIV  = 3'b011;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Remaining edges after the accept edge before the result is captured.
    // A divide by zero never uses the ALU, so it finishes after one edge.
    function automatic logic [CNT_W-1:0] lat_minus_one(
        input logic [2:0] op,
        input logic       div_zero
    );
        logic [CNT_W-1:0] cnt;
        case (op)
            OP_MUL:  cnt = CNT_W'(MUL_LAT - 1);
            OP_DIV: begin
                if (div_zero) begin
                    cnt = '0;
                end else begin
                    cnt = CNT_W'(DIV_LAT - 1);
                end
            end
            default: cnt = '0;
        endcase
        return cnt;
    endfunction

    // Registered state
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             div0_q,       div0_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [2:0]       alu_op_q,     alu_op_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q,    rsp_out_d;
    logic [WIDTH-1:0] rsp_r_q,      rsp_r_d;
    logic             rsp_sign_q,   rsp_sign_d;
    logic             rsp_err_q,    rsp_err_d;
    logic             busy_q,       busy_d;

    // Arbitration results
    logic             grant_valid_s;
    logic             grant_lane_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_div0_s;

    // Round-robin grant: on a tie the lane that did not win last time goes.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_lane_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = ~last_grant_q;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_lane_s  = 1'b0;
        end
    end

    // Operand mux for the granted lane plus divide-by-zero detection.
    always_comb begin
        sel_op_s = 3'b000;
        sel_a_s  = '0;
        sel_b_s  = '0;
        if (grant_lane_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
        sel_div0_s = (sel_op_s == OP_DIV) && (sel_b_s == '0);
    end

    // Ready is only offered in IDLE, and only to the granted lane.
    always_comb begin
        req0_ready = (state_q == ST_IDLE) && grant_valid_s && (grant_lane_s == 1'b0);
        req1_ready = (state_q == ST_IDLE) && grant_valid_s && (grant_lane_s == 1'b1);
    end

    // Next-state logic for the IDLE -> EXEC -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        div0_d       = div0_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_r_d      = rsp_r_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    alu_op_d     = sel_op_s;
                    alu_a_d      = sel_a_s;
                    alu_b_d      = sel_b_s;
                    last_grant_d = grant_lane_s;
                    rsp_id_d     = grant_lane_s;
                    div0_d       = sel_div0_s;
                    cnt_d        = lat_minus_one(sel_op_s, sel_div0_s);
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (cnt_q == '0) begin
                    if (div0_q) begin
                        // The ALU result is meaningless here; report a fixed code.
                        rsp_out_d  = {WIDTH{1'b1}};
                        rsp_r_d    = alu_a_q;
                        rsp_sign_d = 1'b0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        rsp_out_d  = alu_out;
                        rsp_r_d    = alu_r;
                        rsp_sign_d = alu_sign;
                        rsp_err_d  = 1'b0;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_EXEC;
                end
            end

            ST_DONE: begin
                // Pending requests wait until IDLE even if rsp_ready is high.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            div0_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_r_q      <= '0;
            rsp_sign_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            div0_q       <= div0_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_r_q      <= rsp_r_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_sign  = rsp_sign_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
//
// Directed bench for alu_issue_arbiter with a behavioural 16-bit ALU attached.
// Each accepted request pushes its expected response onto a scoreboard queue;
// each response popped from the DUT is compared against it, including the
// number of edges between accept and rsp_valid.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_out, alu_r;
    logic         alu_sign;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_out, rsp_r;
    logic         rsp_sign, rsp_err, busy;

    typedef struct {
        logic         id;
        logic [W-1:0] out;
        logic [W-1:0] r;
        logic         sign;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           exp_last = 1;
    logic [W-1:0] last_out, last_r;
    logic         last_id, last_sign, last_err;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.WIDTH(W), .MUL_LAT(3), .DIV_LAT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_r(alu_r), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_r(rsp_r), .rsp_sign(rsp_sign),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU: returns {sign, r, out}. Divide by zero yields a
    // distinctive junk value that the DUT must not forward.
    function automatic logic [2*W:0] alu_model(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   o, r;
        logic           s;
        p = '0; o = '0; r = '0; s = 1'b0;
        case (op)
            3'b000: o = a + b;
            3'b001: o = a - b;
            3'b010: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                o = p[W-1:0];
                r = p[2*W-1:W];
            end
            3'b011: begin
                if (b != '0) begin
                    o = a / b;
                    r = a % b;
                end else begin
                    o = 16'h0BAD;
                    r = 16'h0BAD;
                end
            end
            3'b100: o = a & b;
            3'b101: o = a | b;
            3'b110: o = {{(W-8){1'b0}}, a[7:0]};
            default: o = a + b;
        endcase
        if (op == 3'b000 || op == 3'b001 || op == 3'b010) s = o[W-1];
        if (op == 3'b011 && b == '0) s = 1'b1;
        return {s, r, o};
    endfunction

    always_comb {alu_sign, alu_r, alu_out} = alu_model(alu_op, alu_a, alu_b);

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (op == 3'b010) return 3;
        if (op == 3'b011 && b != '0) return 8;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (lane == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Wait for an accept, check the grant and push the expected response.
    task automatic wait_accept(output int lane);
        bit           got;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        exp_t         e;
        got  = 1'b0;
        lane = -1;
        for (int w = 0; w < 30 && !got; w++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                check("single_ready", 32'(req0_ready & req1_ready), 32'd0);
                lane = req1_ready ? 1 : 0;
                if (req0_valid && req1_valid)
                    check("rr_grant", 32'(lane), 32'(1 - exp_last));
                else
                    check("sole_grant", 32'(lane), req1_valid ? 32'd1 : 32'd0);
                op = (lane == 1) ? req1_op : req0_op;
                a  = (lane == 1) ? req1_a  : req0_a;
                b  = (lane == 1) ? req1_b  : req0_b;
                e.id  = (lane == 1);
                e.lat = exp_lat(op, b);
                if (op == 3'b011 && b == '0) begin
                    e.out = 16'hFFFF; e.r = a; e.sign = 1'b0; e.err = 1'b1;
                end else begin
                    {e.sign, e.r, e.out} = alu_model(op, a, b);
                    e.err = 1'b0;
                end
                sb_q.push_back(e);
                @(posedge clk); #1;
                exp_last = lane;
                check("alu_op_reg", 32'(alu_op), 32'(op));
                check("alu_a_reg", 32'(alu_a), 32'(a));
                check("alu_b_reg", 32'(alu_b), 32'(b));
            end
        end
        check("accept_seen", 32'(got), 32'd1);
    endtask

    // Count edges until rsp_valid, checking ALU inputs stay put meanwhile.
    task automatic collect_rsp();
        int           cnt;
        bit           stable;
        logic [W-1:0] a0, b0;
        logic [2:0]   op0;
        exp_t         e;
        a0 = alu_a; b0 = alu_b; op0 = alu_op;
        stable = 1'b1;
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (alu_a !== a0 || alu_b !== b0 || alu_op !== op0) stable = 1'b0;
        end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
        check("alu_hold", 32'(stable), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("latency", 32'(cnt), 32'(e.lat));
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_out", 32'(rsp_out), 32'(e.out));
            check("rsp_r", 32'(rsp_r), 32'(e.r));
            check("rsp_sign", 32'(rsp_sign), 32'(e.sign));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        last_out = rsp_out; last_r = rsp_r; last_id = rsp_id;
        last_sign = rsp_sign; last_err = rsp_err;
    endtask

    // One complete operation from a single lane, ending back in IDLE.
    task automatic run_op(input int lane, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int l;
        drive(lane, 1'b1, op, a, b);
        wait_accept(l);
        check("run_lane", 32'(l), 32'(lane));
        drive(lane, 1'b0, op, a, b);
        collect_rsp();
        @(posedge clk); #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic fair_req(input int lane, input int i);
        logic [2:0] op;
        if (i >= 6) begin
            drive(lane, 1'b0, 3'b000, 16'h0000, 16'h0000);
        end else begin
            if (lane == 0) op = (i % 2 == 0) ? 3'b000 : 3'b100;
            else           op = (i == 3) ? 3'b010 : ((i % 2 == 0) ? 3'b101 : 3'b001);
            drive(lane, 1'b1, op, W'(i * 17 + 3 + lane * 100), W'(i * 5 + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           l, i0, i1;
        bit           seen;
        logic [W-1:0] s_out, s_r;
        logic         s_id;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_r", 32'(rsp_r), 32'd0);
        check("rst_rsp_misc", 32'({rsp_id, rsp_sign, rsp_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ready is combinational from valid in IDLE.
        drive(0, 1'b1, 3'b000, 16'd2, 16'd2);
        #1;
        check("ready_same_cycle", 32'(req0_ready), 32'd1);

        // Add
        run_op(0, 3'b000, 16'd2, 16'd2);
        check("add_out", 32'(last_out), 32'd4);
        check("add_id", 32'(last_id), 32'd0);
        check("add_err", 32'(last_err), 32'd0);
        run_op(0, 3'b000, 16'd2, 16'hFFFC);
        check("add_neg_out", 32'(last_out), 32'h0000FFFE);
        check("add_neg_sign", 32'(last_sign), 32'd1);

        // Multiply on lane 1
        run_op(1, 3'b010, 16'd5, 16'd8);
        check("mul_out", 32'(last_out), 32'd40);
        check("mul_r", 32'(last_r), 32'd0);
        check("mul_id", 32'(last_id), 32'd1);

        // Divide and divide by zero
        run_op(0, 3'b011, 16'd13, 16'd3);
        check("div_out", 32'(last_out), 32'd4);
        check("div_r", 32'(last_r), 32'd1);
        run_op(0, 3'b011, 16'd13, 16'd0);
        check("div0_out", 32'(last_out), 32'h0000FFFF);
        check("div0_r", 32'(last_r), 32'd13);
        check("div0_err", 32'(last_err), 32'd1);
        check("div0_sign", 32'(last_sign), 32'd0);

        // Remaining opcodes
        run_op(1, 3'b001, 16'd3, 16'd5);
        run_op(0, 3'b100, 16'hF0F0, 16'h3C3C);
        run_op(1, 3'b101, 16'hF000, 16'h000F);
        run_op(0, 3'b110, 16'h12AB, 16'h0000);
        run_op(1, 3'b111, 16'hFFFF, 16'h0002);
        run_op(0, 3'b010, 16'h1234, 16'h5678);

        // Fairness: both lanes valid continuously, six ops each.
        i0 = 0; i1 = 0;
        fair_req(0, 0);
        fair_req(1, 0);
        for (int k = 0; k < 12; k++) begin
            wait_accept(l);
            if (l == 0) begin i0++; fair_req(0, i0); end
            else if (l == 1) begin i1++; fair_req(1, i1); end
            collect_rsp();
        end
        check("fair_lane0", 32'(i0), 32'd6);
        check("fair_lane1", 32'(i1), 32'd6);
        @(posedge clk); #1;

        // Backpressure while lane 0 keeps requesting.
        rsp_ready = 1'b0;
        drive(0, 1'b1, 3'b000, 16'd7, 16'd9);
        wait_accept(l);
        drive(0, 1'b1, 3'b001, 16'd20, 16'd5);
        collect_rsp();
        s_out = rsp_out; s_r = rsp_r; s_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_out", 32'(rsp_out), 32'(s_out));
            check("bp_r_id", 32'({rsp_r, rsp_id}), 32'({s_r, s_id}));
            check("bp_ready0", 32'(req0_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready0", 32'(req0_ready), 32'd1);
        wait_accept(l);
        check("bp_next_lane", 32'(l), 32'd0);
        drive(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        collect_rsp();
        @(posedge clk); #1;

        // Reset during EXEC drops the operation.
        drive(1, 1'b1, 3'b011, 16'd100, 16'd7);
        wait_accept(l);
        drive(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_alu_a", 32'(alu_a), 32'd0);
        check("rst_exec_alu_op", 32'(alu_op), 32'd0);
        sb_q.delete();
        exp_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_rst", 32'(seen), 32'd0);

        // First tie after reset goes to lane 0.
        drive(0, 1'b1, 3'b000, 16'd1, 16'd1);
        drive(1, 1'b1, 3'b101, 16'd6, 16'd9);
        #1;
        check("tie_ready0", 32'(req0_ready), 32'd1);
        check("tie_ready1", 32'(req1_ready), 32'd0);
        wait_accept(l);
        drive(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        collect_rsp();
        wait_accept(l);
        drive(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        collect_rsp();
        @(posedge clk); #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
